// File: rtl/led_matrix_scanner.sv
// Double-buffered, multi-plane row-scan driver for multiplexed LED matrices.
// Game logic fills the back bank; the front bank is scanned and swaps only at frame ends.
module led_matrix_scanner #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int PLANES = 3,
    parameter int DWELL  = 25000,
    parameter int BLANK  = 16,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [PW-1:0]            wr_plane,
    input  logic [RW-1:0]            wr_row,
    input  logic [COLS-1:0]          wr_data,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     frame_start,
    output logic [RW-1:0]            row_sel,
    output logic                     row_en,
    output logic [PLANES*COLS-1:0]   pix_n
);

    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

    if (DWELL < 2 || BLANK < 0 || BLANK >= DWELL) begin : g_param_check
        $error("led_matrix_scanner: need DWELL >= 2 and 0 <= BLANK < DWELL");
    end

    typedef enum logic {
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t          state;
    logic [COLS-1:0] bank [2][PLANES][ROWS];
    logic            front;
    logic            swap_pend;
    logic [CW-1:0]   slot_cnt;
    logic [CW-1:0]   cnt_next;
    logic            slot_end;
    logic            frame_end;

    assign slot_end    = (slot_cnt == CNT_LAST);
    assign frame_end   = slot_end && (row_sel == ROW_LAST);
    assign cnt_next    = slot_end ? '0 : slot_cnt + 1'b1;
    assign frame_start = (row_sel == '0) && (slot_cnt == '0);
    assign row_en      = (state == S_DRIVE);

    // The blank/drive state is computed from the next count so row_en is a plain register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int p = 0; p < PLANES; p++) begin
                for (int r = 0; r < ROWS; r++) begin
                    bank[0][p][r] <= '0;
                    bank[1][p][r] <= '0;
                end
            end
            front     <= 1'b0;
            swap_pend <= 1'b0;
            slot_cnt  <= '0;
            row_sel   <= '0;
            swap_ack  <= 1'b0;
            state     <= (BLANK > 0) ? S_BLANK : S_DRIVE;
        end else begin
            slot_cnt <= cnt_next;
            state    <= (cnt_next < CNT_BLANK) ? S_BLANK : S_DRIVE;
            swap_ack <= 1'b0;
            if (slot_end) begin
                row_sel <= (row_sel == ROW_LAST) ? '0 : row_sel + 1'b1;
            end
            if (frame_end && (swap_pend || swap_req)) begin
                front     <= ~front;
                swap_pend <= 1'b0;
                swap_ack  <= 1'b1;
            end else if (swap_req) begin
                swap_pend <= 1'b1;
            end
            // Uses the pre-swap back bank, so a write on the swap edge shows immediately.
            if (wr_en && (32'(wr_plane) < PLANES) && (32'(wr_row) < ROWS)) begin
                bank[~front][wr_plane][wr_row] <= wr_data;
            end
        end
    end

    always_comb begin
        pix_n = '1;
        if (state == S_DRIVE) begin
            for (int p = 0; p < PLANES; p++) begin
                pix_n[p*COLS +: COLS] = ~bank[front][p][row_sel];
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: a cycle-count model pushes expected outputs
// after each edge and every scenario task pops and compares them against the DUT.
module tb_led_matrix_scanner;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int PLANES = 2;
    localparam int DWELL  = 6;
    localparam int BLANK  = 2;
    localparam int FRAME  = ROWS * DWELL;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [0:0] wr_plane = '0;
    logic [1:0] wr_row = '0;
    logic [3:0] wr_data = '0;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic       frame_start;
    logic [1:0] row_sel;
    logic       row_en;
    logic [7:0] pix_n;

    typedef struct packed {
        logic [1:0] row;
        logic       en;
        logic [7:0] pix;
        logic       fs;
        logic       ack;
    } out_t;

    out_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic [3:0] m_bank [2][2][4];
    int         m_front = 0;
    logic       m_pend = 1'b0;
    logic       m_ack = 1'b0;
    int         m_t = 0;

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .PLANES(PLANES), .DWELL(DWELL), .BLANK(BLANK)
    ) dut (
        .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_plane(wr_plane), .wr_row(wr_row),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
        .frame_start(frame_start), .row_sel(row_sel), .row_en(row_en), .pix_n(pix_n)
    );

    always #5 CLK = ~CLK;

    // Advance one clock, update the behavioural model from the inputs seen on that edge,
    // and push what the outputs should look like in the following cycle.
    task automatic tick();
        out_t e;
        int   slot;
        int   row;
        @(posedge CLK);
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int p = 0; p < 2; p++)
                    for (int r = 0; r < 4; r++) m_bank[b][p][r] = '0;
            m_front = 0;
            m_pend  = 1'b0;
            m_ack   = 1'b0;
            m_t     = 0;
        end else begin
            if (wr_en) m_bank[1 - m_front][wr_plane][wr_row] = wr_data;
            m_ack = 1'b0;
            if ((m_t % FRAME) == FRAME - 1 && (m_pend || swap_req)) begin
                m_front = 1 - m_front;
                m_pend  = 1'b0;
                m_ack   = 1'b1;
            end else if (swap_req) begin
                m_pend = 1'b1;
            end
            m_t++;
        end
        slot  = m_t % DWELL;
        row   = (m_t / DWELL) % ROWS;
        e.row = 2'(row);
        e.en  = (slot >= BLANK);
        e.fs  = ((m_t % FRAME) == 0);
        e.ack = m_ack;
        e.pix = e.en ? ~{m_bank[m_front][1][row], m_bank[m_front][0][row]} : 8'hFF;
        sb.push_back(e);
        @(negedge CLK);
    endtask

    function automatic out_t observe();
        return {row_sel, row_en, pix_n, frame_start, swap_ack};
    endfunction

    task automatic test_reset();
        out_t e, o;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL reset_hold cyc=%0d got=%h exp=%h", i, o, e);
            end
            checks++;
            if (pix_n !== 8'hFF || row_en !== 1'b0 || swap_ack !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_outputs pix_n=%h row_en=%b swap_ack=%b required FF/0/0",
                         pix_n, row_en, swap_ack);
            end
        end
        reset = 1'b0;
        checks++;
        if (row_sel !== 2'd0 || frame_start !== 1'b1 || row_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release row_sel=%0d frame_start=%b row_en=%b required 0/1/0",
                     row_sel, frame_start, row_en);
        end
    endtask

    task automatic test_free_run();
        out_t e, o;
        int   fs_seen = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL free_run t=%0d got=%h exp=%h", m_t, o, e);
            end
            if (o.fs) fs_seen++;
        end
        checks++;
        if (fs_seen != 2) begin
            failures++;
            $display("[TB] FAIL free_run_frame_starts got=%0d required=2", fs_seen);
        end
    endtask

    task automatic test_write_swap();
        out_t e, o;
        for (int i = 0; i < 40; i++) begin
            wr_en    = (i < 2);
            wr_plane = (i == 0) ? 1'b0 : 1'b1;
            wr_row   = (i == 0) ? 2'd1 : 2'd3;
            wr_data  = (i == 0) ? 4'b1010 : 4'b0001;
            swap_req = ((m_t % FRAME) == 10);
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL write_no_swap t=%0d got=%h exp=%h", m_t, o, e);
            end
            if ((m_t % FRAME) == 0) break;
        end
        wr_en = 1'b0;
        swap_req = 1'b0;
        checks++;
        if (swap_ack !== 1'b1 || frame_start !== 1'b1) begin
            failures++;
            $display("[TB] FAIL swap_ack_at_frame swap_ack=%b frame_start=%b required 1/1",
                     swap_ack, frame_start);
        end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL new_front t=%0d got=%h exp=%h", m_t, o, e);
            end
            if (o.en) begin
                checks++;
                if (o.pix !== ((o.row == 2'd1) ? 8'hF5 : (o.row == 2'd3) ? 8'hEF : 8'hFF)) begin
                    failures++;
                    $display("[TB] FAIL new_front_pixels row=%0d pix_n=%h", o.row, o.pix);
                end
            end
        end
    endtask

    task automatic test_swap_at_frame_end();
        out_t e, o;
        for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) begin
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL to_frame_end t=%0d got=%h exp=%h", m_t, o, e);
            end
        end
        swap_req = 1'b1;
        wr_en    = 1'b1;
        wr_plane = 1'b0;
        wr_row   = 2'd0;
        wr_data  = 4'b1111;
        for (int i = 0; i < FRAME + 1; i++) begin
            tick();
            swap_req = 1'b0;
            wr_en    = 1'b0;
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL edge_swap t=%0d got=%h exp=%h", m_t, o, e);
            end
            if (i == 0) begin
                checks++;
                if (o.ack !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL edge_swap_ack got=%b required=1", o.ack);
                end
            end
            if (o.en && o.row == 2'd0) begin
                checks++;
                if (o.pix[3:0] !== 4'h0) begin
                    failures++;
                    $display("[TB] FAIL edge_swap_row0 pix_n=%h required low nibble 0", o.pix);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        out_t e, o;
        int   acks[$];
        int   bounds = 0;
        for (int i = 0; i < FRAME && (m_t % FRAME) != 0; i++) begin
            tick();
            void'(sb.pop_front());
        end
        swap_req = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL held_swap t=%0d got=%h exp=%h", m_t, o, e);
            end
            if (o.ack) acks.push_back(m_t);
            if ((m_t % FRAME) == 0) bounds++;
            if (bounds == 3) swap_req = 1'b0;
        end
        checks++;
        if (acks.size() != 3) begin
            failures++;
            $display("[TB] FAIL held_swap_count got=%0d required=3", acks.size());
        end else begin
            checks++;
            if (acks[1] - acks[0] != FRAME || acks[2] - acks[1] != FRAME) begin
                failures++;
                $display("[TB] FAIL held_swap_spacing got=%0d,%0d required=%0d",
                         acks[1] - acks[0], acks[2] - acks[1], FRAME);
            end
        end
    endtask

    task automatic test_reset_mid_swap();
        out_t e, o;
        int   acks = 0;
        for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != 13; i++) begin
            swap_req = ((m_t % FRAME) == 3);
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL pre_reset t=%0d got=%h exp=%h", m_t, o, e);
            end
        end
        swap_req = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL mid_reset got=%h exp=%h", o, e);
            end
        end
        reset = 1'b0;
        checks++;
        if (row_sel !== 2'd0 || frame_start !== 1'b1 || swap_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_release row_sel=%0d frame_start=%b swap_ack=%b",
                     row_sel, frame_start, swap_ack);
        end
        for (int i = 0; i < FRAME + 1; i++) begin
            tick();
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL post_reset t=%0d got=%h exp=%h", m_t, o, e);
            end
            if (o.ack) acks++;
            checks++;
            if (o.pix !== 8'hFF) begin
                failures++;
                $display("[TB] FAIL post_reset_cleared row=%0d pix_n=%h required=FF", o.row, o.pix);
            end
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("[TB] FAIL post_reset_ack got=%0d required=0", acks);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_write_swap();
        test_swap_at_frame_end();
        test_back_to_back();
        test_reset_mid_swap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Parametrised, double-buffered, multi-colour scan driver for row-multiplexed LED matrices. It is the generalised successor of the fixed 8x8 R/G per-game display loop.
- Game logic writes whole row bitmaps into a back buffer. The block scans the front buffer one row per slot, with a blanking interval at the start of each slot to suppress ghosting.
- The front and back buffers swap only at a frame boundary, so a displayed frame never tears.

Parameters:
- ROWS, 8, number of scanned rows (row-select codes 0..ROWS-1).
- COLS, 8, pixels per row per colour plane.
- PLANES, 3, colour planes (plane 0=R, 1=G, 2=B/extra).
- DWELL, 25000, CLK cycles per row slot; must be >=2.
- BLANK, 16, blanked cycles at the start of each slot; 0 <= BLANK < DWELL. Violating either constraint is an elaboration error.
- Derived localparams: RW = max(1, clog2(ROWS)); PW = max(1, clog2(PLANES)).

Ports:
- CLK  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write the back buffer this cycle.
- wr_plane  in  PW  target plane.
- wr_row  in  RW  target row.
- wr_data  in  COLS  row bitmap; 1 = pixel lit.
- swap_req  in  1  request a buffer swap at the next frame boundary.
- swap_ack  out  1  one-cycle pulse on the first cycle that shows the new front buffer.
- frame_start  out  1  high on the first cycle of row 0's slot.
- row_sel  out  RW  row currently scanned.
- row_en  out  1  high when pixels are driven (not blanking).
- pix_n  out  PLANES*COLS  active-low pixel drive; plane p occupies bits [p*COLS +: COLS].

Behaviour:
- Storage: two banks, each PLANES x ROWS x COLS bits. A register `front` selects the displayed bank; back = ~front.
- Reset (synchronous): both banks cleared to 0, front=0, swap_pend=0, slot_cnt=0, row_sel=0, swap_ack=0.
  - During reset: pix_n=all 1, row_en=0.
  - First cycle after release: frame_start=1, row_en=0 if BLANK>0.
- Slot counter: slot_cnt counts 0..DWELL-1.
  - At DWELL-1 it returns to 0 and row_sel advances; row_sel wraps ROWS-1 -> 0.
  - One frame = ROWS*DWELL cycles.
- Two-state FSM per slot:
  - BLANK while slot_cnt < BLANK: row_en=0, pix_n=all 1.
  - DRIVE otherwise: row_en=1, pix_n = ~bank[front][p][row_sel] for each plane p.
  - With BLANK=0 the block is always in DRIVE.
- Outputs are decoded from registered state only; there is no input-to-output combinational path.
- frame_start = (row_sel==0 && slot_cnt==0).
- Writes: when wr_en=1, bank[back][wr_plane][wr_row] <= wr_data on the next edge.
  - Out-of-range wr_plane (>=PLANES) or wr_row (>=ROWS) is ignored.
  - Writes never touch the front bank.
- Swap handshake:
  - swap_req=1 sets sticky swap_pend. Further requests while pending have no extra effect (one swap).
  - The frame-end cycle is row_sel==ROWS-1 && slot_cnt==DWELL-1. On that cycle, if (swap_pend | swap_req): front toggles, swap_pend clears, and swap_ack=1 on the next cycle (coincident with frame_start).
  - swap_req asserted exactly on the frame-end cycle is honoured at that boundary.
  - swap_req asserted on the cycle after the boundary waits a full frame.
- Write coincident with the swap edge: the write lands in the pre-swap back bank, so it is visible in the new front immediately.
- The old front becomes the new back with its contents retained (not cleared).
- Reset mid-frame or mid-swap: discards any pending swap and restarts at row 0 per the reset rules.

Test Plan (ROWS=4, COLS=4, PLANES=2, DWELL=6, BLANK=2; frame = 24 cycles):
1. Assert reset 3 cycles, then release.
   -> During reset: pix_n=8'hFF, row_en=0, swap_ack=0.
   -> First cycle after release: row_sel=0, frame_start=1.
2. Free-run 48 cycles.
   -> row_sel steps 0,1,2,3 every 6 cycles.
   -> row_en low on slot cycles 0-1, high on 2-5.
   -> frame_start at cycles 0 and 24 only; pix_n stays 8'hFF (banks empty).
3. Write plane0/row1 = 4'b1010 and plane1/row3 = 4'b0001 with no swap.
   -> Display stays 8'hFF.
   -> Then pulse swap_req mid-frame: swap_ack pulses at the next frame start.
   -> Row1 DRIVE shows pix_n=8'hF5; row3 DRIVE shows pix_n=8'hEF; rows 0 and 2 show 8'hFF.
4. Pulse swap_req exactly on the frame-end cycle, together with a write of plane0/row0 = 4'b1111.
   -> Swap at that boundary; swap_ack next cycle.
   -> Row0 DRIVE shows pix_n low nibble 4'h0.
5. Hold swap_req high for 3 consecutive frame ends.
   -> Exactly three swaps; front alternates; three swap_ack pulses, 24 cycles apart.
6. Pulse swap_req, then assert reset during row 2 before the frame end.
   -> No swap_ack.
   -> After release: row_sel=0, frame_start=1, pix_n=8'hFF in all rows (banks cleared).
